// File: rtl/bus_share_buffer_pkg.sv
// Shared definitions for the bus_share_buffer block.
//   state_t  : FSM encodings (IDLE / DRIVE / TURN)
//   calc_ow  : width of a binary channel index, never below 1 bit
package bus_share_buffer_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_DRIVE = 2'd1,
    STATE_TURN  = 2'd2
  } state_t;

  // Width of a binary index covering n channels. Floors at 1 so the
  // owner/last ports stay well formed even for tiny channel counts.
  function automatic int calc_ow(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_share_buffer_rr_pick.sv
// Round-robin picker for bus_share_buffer.
// Combinational rotate-and-priority-encode: returns the first requesting
// channel when scanning last+1, last+2, ... modulo CHANNELS. The previous
// owner (last) is therefore scanned last and only wins when it is alone.
//   req   in  CHANNELS  request vector, bit i = channel i
//   last  in  OW        index of the previous owner
//   pick  out OW        chosen channel (0 when nothing requests)
//   valid out 1         any request present
module bus_share_buffer_rr_pick
  import bus_share_buffer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int OW       = calc_ow(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [OW-1:0]       last,
  output logic [OW-1:0]       pick,
  output logic                valid
);

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;

  // rot[j] is the request of channel (last+1+j) mod CHANNELS; the doubled
  // vector makes the wrap a plain right shift.
  always_comb begin
    dbl = {req, req} >> (int'(last) + 1);
    rot = dbl[CHANNELS-1:0];
  end

  always_comb begin
    pick  = '0;
    valid = |req;
    // Descending scan so the lowest rotated position (closest to last+1)
    // is the one left standing.
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (rot[j]) pick = OW'((int'(last) + 1 + j) % CHANNELS);
    end
  end

endmodule

// File: rtl/bus_share_buffer.sv
// bus_share_buffer: shares one WIDTH-bit tri-state bus between CHANNELS
// requesters. Round-robin arbitration, grants capped at MAX_HOLD cycles,
// and a mandatory one-cycle high-Z TURN between owners so two drivers can
// never overlap.
//   clk      in   1               rising-edge clock
//   reset    in   1               synchronous, active-high
//   enabled  in   1               output enable; low releases the bus at once
//   req      in   CHANNELS        per-channel request
//   data     in   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   Y        out  WIDTH (tri)     shared bus
//   grant    out  CHANNELS        registered one-hot owner, 0 outside DRIVE
//   owner    out  OW              binary owner index, 0 outside DRIVE
//   busy     out  1               DRIVE or TURN
module bus_share_buffer
  import bus_share_buffer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int MAX_HOLD = 4,
  localparam int OW      = calc_ow(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enabled,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output tri logic [WIDTH-1:0]      Y,
  output logic [CHANNELS-1:0]       grant,
  output logic [OW-1:0]             owner,
  output logic                      busy
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t              state, state_nx;
  logic [CHANNELS-1:0] grant_nx;
  logic [OW-1:0]       owner_nx;
  logic [OW-1:0]       last, last_nx;
  logic [HW-1:0]       hold, hold_nx;

  logic [OW-1:0]       pick;
  logic                pick_valid;
  logic [CHANNELS-1:0] pick_onehot;

  bus_share_buffer_rr_pick #(
    .CHANNELS (CHANNELS),
    .OW       (OW)
  ) u_pick (
    .req   (req),
    .last  (last),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign pick_onehot = CHANNELS'(1) << pick;

  // Next-state and register updates.
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    owner_nx = owner;
    last_nx  = last;
    hold_nx  = hold;
    unique case (state)
      STATE_IDLE, STATE_TURN: begin
        // TURN is an arbitration point exactly like IDLE; it just never
        // lasts more than one cycle.
        state_nx = STATE_IDLE;
        grant_nx = '0;
        owner_nx = '0;
        hold_nx  = '0;
        if (enabled && pick_valid) begin
          state_nx = STATE_DRIVE;
          grant_nx = pick_onehot;
          owner_nx = pick;
          last_nx  = pick;
          hold_nx  = HW'(1);
        end
      end
      STATE_DRIVE: begin
        // Owner's request is read through the registered grant so the
        // check never depends on how owner indexes req.
        if (!(|(req & grant)) || hold == HW'(MAX_HOLD) || !enabled) begin
          state_nx = STATE_TURN;
          grant_nx = '0;
          owner_nx = '0;
          hold_nx  = '0;
        end else begin
          hold_nx = hold + 1'b1;
        end
      end
      default: begin
        state_nx = STATE_IDLE;
        grant_nx = '0;
        owner_nx = '0;
        hold_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATE_IDLE;
      grant <= '0;
      owner <= '0;
      last  <= OW'(CHANNELS - 1);
      hold  <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      owner <= owner_nx;
      last  <= last_nx;
      hold  <= hold_nx;
    end
  end

  assign busy = (state != STATE_IDLE);

  // Bus driver: AND-OR select from the registered one-hot grant, so data
  // changes by the owner appear on Y in the same cycle, and enabled gates
  // the driver combinationally.
  logic [WIDTH-1:0] bus_val;
  logic             drive_en;

  always_comb begin
    bus_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) bus_val = bus_val | data[i*WIDTH +: WIDTH];
    end
  end

  assign drive_en = (state == STATE_DRIVE) && enabled;
  assign Y        = drive_en ? bus_val : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_share_buffer.sv
// Directed bench for bus_share_buffer (WIDTH=4, CHANNELS=4, MAX_HOLD=4).
// Y carries pullups, so a released bus reads as 4'b1111; directed data
// patterns avoid 4'hF so released and driven cycles stay distinguishable.
module tb_bus_share_buffer;

  logic        clk;
  logic        reset;
  logic        enabled;
  logic [3:0]  req;
  logic [15:0] data;
  wire  [3:0]  Y;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;

  int checks;
  int errors;

  localparam logic [3:0] REL = 4'b1111;

  for (genvar i = 0; i < 4; i++) begin : g_pu
    pullup (Y[i]);
  end

  bus_share_buffer #(.WIDTH(4), .CHANNELS(4), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .enabled (enabled),
    .req     (req),
    .data    (data),
    .Y       (Y),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; enabled = 1'b0; req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enabled = 1'b0; req = 4'b0000; data = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({grant, owner, busy, Y} !== {4'b0000, 2'd0, 1'b0, REL}) begin
      errors++;
      $display("FAIL reset_state: got grant=%b owner=%0d busy=%b Y=%b, want 0000/0/0/1111",
               grant, owner, busy, Y);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] eg, ey;
    enabled = 1'b1; req = 4'b0001; data = 16'h000A;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      eg = ((k % 5) < 4) ? 4'b0001 : 4'b0000;
      ey = ((k % 5) < 4) ? 4'hA : REL;
      checks++;
      if ({grant, busy, Y} !== {eg, 1'b1, ey} || (eg != 0 && owner !== 2'd0)) begin
        errors++;
        $display("FAIL single_c%0d: got grant=%b busy=%b Y=%b owner=%0d, want %b/1/%b/0",
                 k, grant, busy, Y, owner, eg, ey);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({grant, busy, Y} !== {4'b0000, 1'b0, REL}) begin
      errors++;
      $display("FAIL single_idle: got grant=%b busy=%b Y=%b, want 0000/0/1111", grant, busy, Y);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] eg, ey;
    int ch;
    do_reset();
    enabled = 1'b1; req = 4'b1111; data = 16'h4321;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      ch = (k / 5) % 4;
      eg = ((k % 5) < 4) ? (4'b0001 << ch) : 4'b0000;
      ey = ((k % 5) < 4) ? 4'(ch + 1) : REL;
      checks++;
      if ({grant, busy, Y} !== {eg, 1'b1, ey} || (eg != 0 && owner !== 2'(ch))) begin
        errors++;
        $display("FAIL rotation_c%0d: got grant=%b busy=%b Y=%b owner=%0d, want %b/1/%b/%0d",
                 k, grant, busy, Y, owner, eg, ey, ch);
      end
    end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_early_release();
    do_reset();
    enabled = 1'b1; data = 16'h4321; req = 4'b0100;
    @(negedge clk);
    checks++;
    if ({grant, owner, Y} !== {4'b0100, 2'd2, 4'h3}) begin
      errors++;
      $display("FAIL early_c1: got grant=%b owner=%0d Y=%b, want 0100/2/0011", grant, owner, Y);
    end
    req = 4'b1101;
    @(negedge clk);
    req = 4'b1001;
    #1;
    checks++;
    if ({grant, busy, Y} !== {4'b0100, 1'b1, 4'h3}) begin
      errors++;
      $display("FAIL early_drop_cycle: got grant=%b busy=%b Y=%b, want 0100/1/0011", grant, busy, Y);
    end
    @(negedge clk);
    checks++;
    if ({grant, busy, Y} !== {4'b0000, 1'b1, REL}) begin
      errors++;
      $display("FAIL early_turn: got grant=%b busy=%b Y=%b, want 0000/1/1111", grant, busy, Y);
    end
    @(negedge clk);
    checks++;
    if ({grant, owner, Y} !== {4'b1000, 2'd3, 4'h4}) begin
      errors++;
      $display("FAIL early_next_owner: got grant=%b owner=%0d Y=%b, want 1000/3/0100", grant, owner, Y);
    end
  endtask

  task automatic test_enable();
    do_reset();
    enabled = 1'b0; req = 4'b0101; data = 16'h4321;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({grant, busy, Y} !== {4'b0000, 1'b0, REL}) begin
        errors++;
        $display("FAIL enable_off_c%0d: got grant=%b busy=%b Y=%b, want 0000/0/1111", k, grant, busy, Y);
      end
    end
    enabled = 1'b1;
    @(negedge clk);
    checks++;
    if ({grant, owner, Y} !== {4'b0001, 2'd0, 4'h1}) begin
      errors++;
      $display("FAIL enable_grant: got grant=%b owner=%0d Y=%b, want 0001/0/0001", grant, owner, Y);
    end
    data[3:0] = 4'h6;
    #1;
    checks++;
    if (Y !== 4'h6) begin
      errors++;
      $display("FAIL enable_data_follow: got Y=%b, want 0110", Y);
    end
    enabled = 1'b0;
    #1;
    checks++;
    if ({grant, Y} !== {4'b0001, REL}) begin
      errors++;
      $display("FAIL enable_drop_comb: got grant=%b Y=%b, want 0001/1111", grant, Y);
    end
    @(negedge clk);
    checks++;
    if ({grant, busy, Y} !== {4'b0000, 1'b1, REL}) begin
      errors++;
      $display("FAIL enable_turn: got grant=%b busy=%b Y=%b, want 0000/1/1111", grant, busy, Y);
    end
    @(negedge clk);
    checks++;
    if ({grant, busy, Y} !== {4'b0000, 1'b0, REL}) begin
      errors++;
      $display("FAIL enable_idle: got grant=%b busy=%b Y=%b, want 0000/0/1111", grant, busy, Y);
    end
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    enabled = 1'b1; data = 16'h4321; req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({grant, busy, Y} !== {4'b0010, 1'b1, 4'h2}) begin
      errors++;
      $display("FAIL rstmid_drive: got grant=%b busy=%b Y=%b, want 0010/1/0010", grant, busy, Y);
    end
    reset = 1'b1; req = 4'b1111;
    @(negedge clk);
    checks++;
    if ({grant, busy, Y} !== {4'b0000, 1'b0, REL}) begin
      errors++;
      $display("FAIL rstmid_release: got grant=%b busy=%b Y=%b, want 0000/0/1111", grant, busy, Y);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({grant, owner, Y} !== {4'b0001, 2'd0, 4'h1}) begin
      errors++;
      $display("FAIL rstmid_regrant: got grant=%b owner=%0d Y=%b, want 0001/0/0001", grant, owner, Y);
    end
  endtask

  task automatic test_random();
    logic [3:0] prev;
    logic [3:0] ey;
    int run;
    do_reset();
    prev = 4'b0000; run = 0;
    for (int k = 0; k < 1000; k++) begin
      req     = 4'($urandom_range(0, 15));
      enabled = ($urandom_range(0, 7) != 0);
      data    = 16'($urandom);
      @(negedge clk);
      checks++;
      if ($countones(grant) > 1) begin
        errors++;
        $display("FAIL rand_onehot_c%0d: got grant=%b, want at most one bit", k, grant);
      end
      checks++;
      if (grant != 0 && prev != 0 && grant != prev) begin
        errors++;
        $display("FAIL rand_gap_c%0d: got grant %b after %b, want a 0000 cycle between", k, grant, prev);
      end
      run = (grant != 0 && grant == prev) ? run + 1 : ((grant != 0) ? 1 : 0);
      checks++;
      if (run > 4) begin
        errors++;
        $display("FAIL rand_hold_c%0d: got run=%0d, want <=4", k, run);
      end
      ey = REL;
      for (int i = 0; i < 4; i++) if (grant[i] && enabled) ey = data[i*4 +: 4];
      checks++;
      if (Y !== ey) begin
        errors++;
        $display("FAIL rand_bus_c%0d: got Y=%b, want %b", k, Y, ey);
      end
      prev = grant;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; enabled = 1'b0; req = 4'b0000; data = 16'h0000;
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_enable();
    test_reset_mid_drive();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_share_buffer.md
# bus_share_buffer

Parametrised, clocked successor to the team's 4-bit tri-state buffer. Multiplexes CHANNELS requesters onto one shared WIDTH-bit tri-state bus. Arbitration is round-robin, each grant is limited to MAX_HOLD cycles, and the block inserts a mandatory one-cycle high-Z turnaround between owners so two drivers never overlap. It sits between the lab's register/ALU sources and the shared data bus.

## Interface
- WIDTH, 4: bus and per-channel data width (≥1).
- CHANNELS, 4: number of requesters (≥2).
- MAX_HOLD, 4: maximum consecutive drive cycles per grant (≥1).
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- enabled  in  1  global output enable; low forces bus to high-Z.
- req  in  CHANNELS  per-channel bus request, bit i = channel i.
- data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- Y  out (tri)  WIDTH  shared bus; driven only in DRIVE with enabled high, else 'z.
- grant  out  CHANNELS  registered one-hot owner, all-zero when not in DRIVE.
- owner  out  OW  binary index of current owner, OW = max(1, clog2(CHANNELS)); 0 when idle.
- busy  out  1  high while in DRIVE or TURN.

## Operation
- Registered states:
  - IDLE: no owner.
  - DRIVE: an owner holds the bus.
  - TURN: one-cycle high-Z gap.
- Other registers:
  - last: index of the previous owner; reset to CHANNELS-1, so channel 0 wins first.
  - hold: drive-cycle counter, clog2(MAX_HOLD+1) bits.
- Round-robin pick: the first asserted req scanning last+1, last+2, … wrapping modulo CHANNELS. The previous owner is eligible only if no other channel requests.
- IDLE:
  - Goes to DRIVE if enabled && |req.
  - On entry: grant=onehot(pick), owner=pick, last=pick, hold=1.
  - Otherwise stays in IDLE.
- DRIVE:
  - Exits to TURN if any of: req[owner]==0, hold==MAX_HOLD, or enabled==0.
  - Otherwise stays and increments hold.
  - Owner never changes within DRIVE.
- TURN:
  - grant=0, Y='z, always lasts exactly one cycle.
  - Next state is DRIVE (with a new pick, same entry actions as IDLE) if enabled && |req, else IDLE.
- Y = data slice of owner when state==DRIVE && enabled, else 'z.
  - Y is combinational from the registered grant, the current data and enabled.
  - Data changes by the owner propagate to Y the same cycle.
- enabled low during DRIVE: Y goes 'z immediately (combinationally); the FSM enters TURN at the next edge.
- req of non-owners is ignored until the next arbitration point.

## Timing
- Reset values: state=IDLE, grant=0, owner=0, busy=0, Y='z, last=CHANNELS-1, hold=0.
- Reset has priority over every transition. Asserted mid-DRIVE, it releases the bus at the next edge with no TURN cycle.
- Grant latency: req sampled high at edge n → grant/Y valid after edge n (one cycle from request to drive).
- Back-to-back owners: each DRIVE run is ≤MAX_HOLD cycles, followed by exactly one TURN cycle. Bus utilisation with continuous requests is MAX_HOLD/(MAX_HOLD+1).
- A single continuous requester is re-granted after each TURN; it never holds more than MAX_HOLD consecutive cycles.
- An owner dropping req in DRIVE cycle k: it still drives through cycle k because the registered grant is unchanged until the edge; its DRIVE run ends after cycle k.
- req and enabled are assumed synchronous to clk; no internal synchronisers.

## Structure
- Shared include/package holds:
  - state encodings STATE_IDLE=2'd0, STATE_DRIVE=2'd1, STATE_TURN=2'd2;
  - the OW width helper.
- Sub-module rr_pick:
  - inputs: req [CHANNELS], last [OW];
  - outputs: pick [OW], valid.
  - Purely combinational rotate-and-priority-encode.
- The top holds the FSM, counters and the tri-state driver.

## Test plan
- Reset mid-DRIVE: defaults WIDTH=4, CHANNELS=4, MAX_HOLD=4; assert reset in DRIVE → grant=0000, Y=zzzz, busy=0 after the edge; the next grant goes to channel 0.
- Single channel: req=0001, data0=4'b1010, held continuously → Y=1010 for 4 cycles, Y=zzzz for 1 cycle, repeating; grant toggles 0001/0000.
- Rotation: req=1111, data slices ch0=4'h1, ch1=4'h2, ch2=4'h3, ch3=4'h4 → owner sequence 0,1,2,3,0 with one high-Z cycle between each.
- Early release: ch2 owner drops req after 2 DRIVE cycles → TURN on the next cycle; ch3 wins ahead of ch0 (round-robin order).
- Enable gating: enabled=0 with req=0101 → Y stays zzzz and grant=0. Dropping enabled mid-DRIVE → Y=zzzz in the same cycle, TURN next, IDLE afterwards.
- No overlap check: randomised req for 1000 cycles → popcount(grant)≤1 every cycle, and every owner change has a grant=0 cycle between.
